// File: rtl/input_memory_reader_pkg.sv
// Shared definitions for the input memory reader and the output memory manager.
// The state encoding and the word width are kept here so that producer and consumer
// always agree on them.
package input_memory_reader_pkg;

  // Outputs per row, fixed to match the consumer's one-hot accumulator ring.
  localparam int unsigned N_OUTPUTS = 8;
  // Bits needed to index one output within a row.
  localparam int unsigned COL_W     = 3;
  // Width of activation and weight words.
  localparam int unsigned DATA_W    = 16;

  typedef logic [2:0] imr_state_t;

  localparam imr_state_t IDLE   = 3'd0;
  localparam imr_state_t LOAD_Z = 3'd1;
  localparam imr_state_t STREAM = 3'd2;
  localparam imr_state_t FLUSH  = 3'd3;
  localparam imr_state_t DONE   = 3'd4;

endpackage

// File: rtl/imr_addr_gen.sv
// Row/column counters for the input memory reader.
//   clock, clear : system clock, synchronous active-high reset
//   issue_i      : one weight read is issued this cycle (advances j)
//   skip_i       : the current row is abandoned without issuing (advances i)
//   row_o        : current row i, used as the activation address
//   waddr_o      : weight address {i, j}
//   row_done_o   : the current row finishes this cycle
//   last_row_o   : i is the final row
module imr_addr_gen
  import input_memory_reader_pkg::*;
#(
  parameter int unsigned N_INPUTS = 16,
  localparam int unsigned IW      = $clog2(N_INPUTS)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                issue_i,
  input  logic                skip_i,
  output logic [IW-1:0]       row_o,
  output logic [IW+COL_W-1:0] waddr_o,
  output logic                row_done_o,
  output logic                last_row_o
);

  logic [IW-1:0]    i_q, i_d;
  logic [COL_W-1:0] j_q, j_d;
  logic             last_col;

  assign last_col   = (j_q == COL_W'(N_OUTPUTS - 1));
  assign last_row_o = (i_q == IW'(N_INPUTS - 1));
  assign row_done_o = skip_i | (issue_i & last_col);
  assign row_o      = i_q;
  assign waddr_o    = {i_q, j_q};

  always_comb begin
    j_d = j_q;
    i_d = i_q;
    if (issue_i) begin
      j_d = last_col ? '0 : j_q + COL_W'(1);
    end
    // i stays on the final row; the FSM moves to FLUSH instead.
    if (row_done_o && !last_row_o) begin
      i_d = i_q + IW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/input_memory_reader.sv
// Input memory reader: fetches each activation from the input RAM and the eight
// matching weights from the weight RAM, then streams (active_z, active_m) pairs with
// one next_element pulse per MAC, row by row. last_element/finished rise once all
// pairs have been delivered and hold until clear.
// Ports:
//   clock, clear              : system clock, synchronous active-high reset
//   en                        : start in IDLE, issue permit in STREAM
//   input_ram_*               : activation read port (data one cycle after enable)
//   weight_ram_*              : weight read port, address {i, j}
//   active_z, active_m        : current pair, held between pulses
//   next_element              : one-cycle pulse per pair
//   last_element, finished    : level, reader is DONE
// Build option: define ZERO_SKIP_EN to skip rows whose activation is zero.
module input_memory_reader
  import input_memory_reader_pkg::*;
#(
  parameter int unsigned N_INPUTS = 16,
  localparam int unsigned IW      = $clog2(N_INPUTS)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                en,
  output logic [IW-1:0]       input_ram_address,
  output logic                input_ram_enable,
  input  logic [DATA_W-1:0]   input_ram_data,
  output logic [IW+COL_W-1:0] weight_ram_address,
  output logic                weight_ram_enable,
  input  logic [DATA_W-1:0]   weight_ram_data,
  output logic [DATA_W-1:0]   active_z,
  output logic [DATA_W-1:0]   active_m,
  output logic                next_element,
  output logic                last_element,
  output logic                finished
);

  imr_state_t        state_q, state_d;
  logic              first_q;   // first STREAM cycle: activation data is on the bus
  logic              valid_q;   // weight read issued last cycle
  logic [DATA_W-1:0] z_hold_q;  // activation of the row being streamed
  logic [DATA_W-1:0] z_pipe_q;  // activation travelling alongside the weight read
  logic              next_q;
  logic [DATA_W-1:0] az_q, am_q;

  logic [DATA_W-1:0] z_cur;
  logic              issue, skip, row_done, last_row;
  logic [IW-1:0]     row;
  logic [IW+COL_W-1:0] waddr;

  assign z_cur = first_q ? input_ram_data : z_hold_q;

`ifdef ZERO_SKIP_EN
  assign skip = (state_q == STREAM) && first_q && (input_ram_data == '0);
`else
  assign skip = 1'b0;
`endif

  assign issue = (state_q == STREAM) && en && !skip;

  imr_addr_gen #(
    .N_INPUTS(N_INPUTS)
  ) u_addr_gen (
    .clock     (clock),
    .clear     (clear),
    .issue_i   (issue),
    .skip_i    (skip),
    .row_o     (row),
    .waddr_o   (waddr),
    .row_done_o(row_done),
    .last_row_o(last_row)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = LOAD_Z;
      LOAD_Z:  state_d = STREAM;
      STREAM:  if (row_done) state_d = last_row ? FLUSH : LOAD_Z;
      // Once no read is in flight the final pulse is emerging this cycle, so DONE
      // becomes visible exactly one cycle after it.
      FLUSH:   if (!valid_q) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= IDLE;
      first_q  <= 1'b0;
      valid_q  <= 1'b0;
      z_hold_q <= '0;
      z_pipe_q <= '0;
      next_q   <= 1'b0;
      az_q     <= '0;
      am_q     <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_q == LOAD_Z);
      valid_q <= issue;
      next_q  <= valid_q;
      if (first_q) z_hold_q <= input_ram_data;
      if (issue)   z_pipe_q <= z_cur;
      if (valid_q) begin
        az_q <= z_pipe_q;
        am_q <= weight_ram_data;
      end
    end
  end

  assign input_ram_enable   = (state_q == LOAD_Z);
  assign input_ram_address  = row;
  assign weight_ram_enable  = issue;
  assign weight_ram_address = waddr;
  assign active_z           = az_q;
  assign active_m           = am_q;
  assign next_element       = next_q;
  assign last_element       = (state_q == DONE);
  assign finished           = (state_q == DONE);

endmodule

// File: tb/tb_input_memory_reader.sv
module tb_input_memory_reader;

  localparam int unsigned NI = 2;
  localparam int unsigned IW = $clog2(NI);
  localparam int unsigned DW = 16;
  localparam int unsigned NP = NI * 8;

`ifdef ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          clear, en;
  logic [IW-1:0] input_ram_address;
  logic          input_ram_enable;
  logic [DW-1:0] input_ram_data;
  logic [IW+2:0] weight_ram_address;
  logic          weight_ram_enable;
  logic [DW-1:0] weight_ram_data;
  logic [DW-1:0] active_z, active_m;
  logic          next_element, last_element, finished;

  always #5 clock = ~clock;

  input_memory_reader #(
    .N_INPUTS(NI)
  ) dut (
    .clock             (clock),
    .clear             (clear),
    .en                (en),
    .input_ram_address (input_ram_address),
    .input_ram_enable  (input_ram_enable),
    .input_ram_data    (input_ram_data),
    .weight_ram_address(weight_ram_address),
    .weight_ram_enable (weight_ram_enable),
    .weight_ram_data   (weight_ram_data),
    .active_z          (active_z),
    .active_m          (active_m),
    .next_element      (next_element),
    .last_element      (last_element),
    .finished          (finished)
  );

  // Synchronous-read RAM models.
  logic [DW-1:0] zmem [NI];
  logic [DW-1:0] wmem [NP];
  always @(posedge clock) begin
    if (input_ram_enable)  input_ram_data  <= zmem[input_ram_address];
    if (weight_ram_enable) weight_ram_data <= wmem[weight_ram_address];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: the ordered list of pairs and addresses a run must produce.
  int exp_z[$], exp_m[$], exp_wa[$], exp_ia[$];
  int got_wa[$], got_ia[$];
  int exp_count;

  function automatic void build_model();
    exp_z.delete(); exp_m.delete(); exp_wa.delete(); exp_ia.delete();
    for (int i = 0; i < NI; i++) begin
      exp_ia.push_back(i);
      if (!(ZS && zmem[i] == 0)) begin
        for (int j = 0; j < 8; j++) begin
          exp_z.push_back(int'(zmem[i]));
          exp_m.push_back(int'(wmem[i*8+j]));
          exp_wa.push_back(i * 8 + j);
        end
      end
    end
    exp_count = exp_z.size();
  endfunction

  // Monitor
  int     pulse_cnt, cyc, last_pulse_cyc, done_cyc;
  bit     mon_on = 1'b0;
  bit     done_seen;
  longint acc [8];

  always @(negedge clock) begin
    cyc++;
    if (mon_on) begin
      if (input_ram_enable)  got_ia.push_back(int'(input_ram_address));
      if (weight_ram_enable) got_wa.push_back(int'(weight_ram_address));
      if (next_element) begin
        check_eq("no_overlap", longint'(last_element), 0);
        if (exp_z.size() == 0) begin
          check_eq("extra_pulse", pulse_cnt + 1, exp_count);
        end else begin
          check_eq("active_z", longint'(active_z), exp_z.pop_front());
          check_eq("active_m", longint'(active_m), exp_m.pop_front());
        end
        acc[pulse_cnt % 8] += longint'(active_z) * longint'(active_m);
        pulse_cnt++;
        last_pulse_cyc = cyc;
      end
      if (last_element && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (last_element) begin
        check_eq("done_no_strobe", longint'(input_ram_enable | weight_ram_enable), 0);
      end
    end
  end

  // mode 0: en always high; 1: stall after third weight issue of row 0; 2: random en.
  task automatic run(input int mode, input int abort_at, output bit aborted);
    aborted = 1'b0;
    en      = 1'b0;
    clear   = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    build_model();
    got_wa.delete(); got_ia.delete();
    pulse_cnt = 0; last_pulse_cyc = 0; done_cyc = 0; done_seen = 1'b0;
    foreach (acc[k]) acc[k] = 0;
    mon_on = 1'b1;
    for (int k = 0; k < 400 && !last_element; k++) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = !(k >= 5 && k <= 8);
        default: en = (k == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
      endcase
      @(negedge clock); #1;
      if (mode == 1 && k >= 5 && k <= 8) begin
        check_eq("stall_no_strobe", longint'(weight_ram_enable), 0);
      end
      if (abort_at != 0 && pulse_cnt == abort_at) begin
        aborted = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!aborted) begin
      en = 1'b0;
      @(negedge clock); #1;
      check_eq("last_element", longint'(last_element), 1);
      check_eq("finished", longint'(finished), 1);
      check_eq("pulse_count", pulse_cnt, exp_count);
      check_eq("waddr_count", got_wa.size(), exp_wa.size());
      check_eq("iaddr_count", got_ia.size(), exp_ia.size());
      for (int n = 0; n < got_wa.size() && n < exp_wa.size(); n++)
        check_eq("weight_addr", got_wa[n], exp_wa[n]);
      for (int n = 0; n < got_ia.size() && n < exp_ia.size(); n++)
        check_eq("input_addr", got_ia[n], exp_ia[n]);
      if (exp_count > 0) begin
        check_eq("done_after_pulse", longint'(done_cyc > last_pulse_cyc), 1);
        if (!ZS || zmem[NI-1] != 0) check_eq("done_timing", done_cyc, last_pulse_cyc + 1);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_next"}, longint'(next_element), 0);
    check_eq({tag, "_last"}, longint'(last_element), 0);
    check_eq({tag, "_fin"}, longint'(finished), 0);
    check_eq({tag, "_az"}, longint'(active_z), 0);
    check_eq({tag, "_am"}, longint'(active_m), 0);
    check_eq({tag, "_strobes"}, longint'(input_ram_enable | weight_ram_enable), 0);
    check_eq({tag, "_addr"}, longint'(input_ram_address) + longint'(weight_ram_address), 0);
  endtask

  bit ab;

  initial begin
    clear = 1'b1;
    en    = 1'b0;
    for (int i = 0; i < NI; i++) zmem[i] = '0;
    for (int i = 0; i < NP; i++) wmem[i] = '0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");

    // Directed: z = {3, 5}, W = 8i + j + 1.
    zmem[0] = 16'd3;
    zmem[1] = 16'd5;
    for (int i = 0; i < NP; i++) wmem[i] = DW'(i + 1);
    run(0, 0, ab);
    check_eq("acc_w0", acc[0], 48);
    check_eq("acc_w7", acc[7], 104);

    // Done holds while en toggles; drops only on clear.
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      en = 1'(($urandom_range(1, 0)));
      @(negedge clock); #1;
      check_eq("hold_last", longint'(last_element), 1);
      check_eq("hold_fin", longint'(finished), 1);
    end
    mon_on = 1'b0;
    en = 1'b0;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    check_eq("clear_drops_last", longint'(last_element), 0);

    // Stall mid-row, sequence must be unchanged.
    run(1, 0, ab);

    // Clear at the fifth pulse, then replay from pair 0.
    run(0, 5, ab);
    check_eq("aborted", longint'(ab), 1);
    mon_on = 1'b0;
    en     = 1'b0;
    clear  = 1'b1;
    @(posedge clock); #1;
    check_all_zero("midclear");
    clear = 1'b0;
    @(posedge clock); #1;
    check_eq("idle_no_strobe", longint'(input_ram_enable | weight_ram_enable), 0);
    run(0, 0, ab);

    // Zero activation in row 0.
    zmem[0] = 16'd0;
    zmem[1] = 16'd5;
    run(0, 0, ab);

    // Random activations (with zeros), weights and en.
    for (int r = 0; r < 50; r++) begin
      for (int i = 0; i < NI; i++)
        zmem[i] = ($urandom_range(2, 0) == 0) ? 16'd0 : DW'($urandom);
      for (int i = 0; i < NP; i++) wmem[i] = DW'($urandom);
      run(2, 0, ab);
    end

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
